// File: rtl/vdp_vram_arb.sv
// Arbitrates NCH requesters onto one asynchronous 8-bit SRAM port (VDP video RAM).
// Latency: grant edge to ack pulse is WAIT+2 cycles; back-to-back grants every WAIT+3 cycles.
// Backpressure: no queuing; each requester holds req until its one-cycle ack pulse.
module vdp_vram_arb #(
    parameter int NCH  = 3,
    parameter int AW   = 14,
    parameter int WAIT = 1,
    parameter int RR   = 0
) (
    input  logic              clk40m,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    wr,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*8-1:0]  wdata,
    output logic [NCH-1:0]    ack,
    output logic [7:0]        rdata,
    output logic [AW-1:0]     sram_a,
    input  logic [7:0]        sram_din,
    output logic [7:0]        sram_dout,
    output logic              sram_doe,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int LGW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LGW-1:0]  win_q, win_d;
    logic [LGW-1:0]  last_grant_q, last_grant_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   sram_a_q, sram_a_d;
    logic [7:0]      sram_dout_q, sram_dout_d;
    logic [7:0]      rdata_q, rdata_d;

    logic            any_req;
    logic [LGW-1:0]  grant_idx;
    logic [LGW-1:0]  lo_pick;
    logic [LGW-1:0]  hi_pick;
    logic            hi_found;
    logic            sel_wr;
    logic [AW-1:0]   sel_addr;
    logic [7:0]      sel_wdata;

    assign any_req = |req;

    // Winner selection: lowest requester overall, or (round-robin) the lowest
    // requester above the last grant, wrapping to the lowest overall.
    always_comb begin
        lo_pick   = '0;
        hi_pick   = '0;
        hi_found  = 1'b0;
        grant_idx = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_pick = LGW'(j);
            end
            if (req[j] && (LGW'(j) > last_grant_q)) begin
                hi_pick  = LGW'(j);
                hi_found = 1'b1;
            end
        end
        if (NCH == 1) begin
            grant_idx = '0;
        end else if ((RR != 0) && hi_found) begin
            grant_idx = hi_pick;
        end else begin
            grant_idx = lo_pick;
        end
    end

    // Pick the winning channel's request fields out of the packed buses.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == LGW'(i)) begin
                sel_wr    = wr[i];
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*8 +: 8];
            end
        end
    end

    // State register and latched access parameters; reset abandons any access.
    always_ff @(posedge clk40m or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            win_q        <= '0;
            last_grant_q <= LGW'(NCH - 1);
            wr_q         <= 1'b0;
            sram_a_q     <= '0;
            sram_dout_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            sram_a_q     <= sram_a_d;
            sram_dout_q  <= sram_dout_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state: grant in IDLE, count down WAIT+1 strobe cycles, one DONE cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        sram_a_d     = sram_a_q;
        sram_dout_d  = sram_dout_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    win_d        = grant_idx;
                    last_grant_d = grant_idx;
                    wr_d         = sel_wr;
                    sram_a_d     = sel_addr;
                    sram_dout_d  = sel_wdata;
                    cnt_d        = CW'(WAIT);
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!wr_q) begin
                        rdata_d = sram_din;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ack pulse goes only to the latched winner, during DONE.
    always_comb begin
        ack = '0;
        for (int i = 0; i < NCH; i++) begin
            ack[i] = (state_q == S_DONE) && (win_q == LGW'(i));
        end
    end

    // SRAM strobes decoded from registered state only, so reset clears them
    // at once; the first write cycle is left as address setup before we_n.
    always_comb begin
        sram_oe_n = !((state_q == S_ACCESS) && !wr_q);
        sram_we_n = !((state_q == S_ACCESS) && wr_q && (cnt_q != CW'(WAIT)));
        sram_doe  = wr_q && (state_q != S_IDLE);
    end

    assign sram_a    = sram_a_q;
    assign sram_dout = sram_dout_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_vdp_vram_arb.sv
// Bench for vdp_vram_arb: fixed-priority, round-robin and slow-SRAM single-channel instances.
// Table vectors go through a scoreboard queue; multi-cycle corners are hand sequences.
// All waits on the DUT are bounded by cycle budgets.
module tb_vdp_vram_arb;

    localparam int FP_WAIT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // fixed-priority instance, NCH=3 AW=14 WAIT=1
    logic [2:0]  fp_req, fp_wr, fp_ack;
    logic [41:0] fp_addr;
    logic [23:0] fp_wdata;
    logic [7:0]  fp_rdata, fp_din, fp_dout;
    logic [13:0] fp_a;
    logic        fp_doe, fp_oe_n, fp_we_n;

    // round-robin instance
    logic [2:0]  rr_req, rr_wr, rr_ack;
    logic [41:0] rr_addr;
    logic [23:0] rr_wdata;
    logic [7:0]  rr_rdata, rr_dout;
    logic [13:0] rr_a;
    logic        rr_doe, rr_oe_n, rr_we_n;

    // single channel, AW=17, WAIT=3
    logic [0:0]  w3_req, w3_wr, w3_ack;
    logic [16:0] w3_addr, w3_a;
    logic [7:0]  w3_wdata, w3_rdata, w3_din, w3_dout;
    logic        w3_doe, w3_oe_n, w3_we_n;

    vdp_vram_arb #(.NCH(3), .AW(14), .WAIT(FP_WAIT), .RR(0)) u_fp (
        .clk40m(clk), .rst(rst), .req(fp_req), .wr(fp_wr), .addr(fp_addr),
        .wdata(fp_wdata), .ack(fp_ack), .rdata(fp_rdata), .sram_a(fp_a),
        .sram_din(fp_din), .sram_dout(fp_dout), .sram_doe(fp_doe),
        .sram_oe_n(fp_oe_n), .sram_we_n(fp_we_n)
    );

    vdp_vram_arb #(.NCH(3), .AW(14), .WAIT(1), .RR(1)) u_rr (
        .clk40m(clk), .rst(rst), .req(rr_req), .wr(rr_wr), .addr(rr_addr),
        .wdata(rr_wdata), .ack(rr_ack), .rdata(rr_rdata), .sram_a(rr_a),
        .sram_din(8'h5A), .sram_dout(rr_dout), .sram_doe(rr_doe),
        .sram_oe_n(rr_oe_n), .sram_we_n(rr_we_n)
    );

    vdp_vram_arb #(.NCH(1), .AW(17), .WAIT(3), .RR(1)) u_w3 (
        .clk40m(clk), .rst(rst), .req(w3_req), .wr(w3_wr), .addr(w3_addr),
        .wdata(w3_wdata), .ack(w3_ack), .rdata(w3_rdata), .sram_a(w3_a),
        .sram_din(w3_din), .sram_dout(w3_dout), .sram_doe(w3_doe),
        .sram_oe_n(w3_oe_n), .sram_we_n(w3_we_n)
    );

    // SRAM model for the fixed-priority instance; 0x1234 preloaded with 0xA5
    logic [7:0] fp_mem [0:16383];
    assign fp_din = fp_mem[fp_a];
    always @(posedge clk) begin
        if (rst) fp_mem[14'h1234] <= 8'hA5;
        else if (!fp_we_n) fp_mem[fp_a] <= fp_dout;
    end

    assign w3_din = (w3_a == 17'h1FFFF) ? 8'hC3 : 8'h00;

    typedef struct {
        int         ch;
        logic       w;
        logic [13:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        int         ch;
        logic [7:0] rd;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One transaction on u_fp: address fields are scrambled right after the
    // grant, which must not disturb the access in flight.
    task automatic run_fp(input vec_t v);
        int   oe_lo, we_lo, doe_hi, lat;
        bit   got;
        logic [13:0] a0;
        logic [7:0]  d0;
        logic [2:0]  ackv;
        exp_t e;
        oe_lo = 0; we_lo = 0; doe_hi = 0; lat = -1; got = 0;
        a0 = '0; d0 = '0; ackv = '0;
        @(negedge clk);
        fp_req[v.ch] = 1'b1;
        fp_wr[v.ch] = v.w;
        fp_addr[v.ch*14 +: 14] = v.a;
        fp_wdata[v.ch*8 +: 8] = v.d;
        sb.push_back('{v.ch, v.exp_rd});
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (!fp_oe_n) oe_lo++;
            if (!fp_we_n) we_lo++;
            if (fp_doe) doe_hi++;
            if (n == 0) begin
                a0 = fp_a;
                d0 = fp_dout;
                fp_addr[v.ch*14 +: 14] = ~v.a;
                fp_wdata[v.ch*8 +: 8] = ~v.d;
                fp_wr[v.ch] = ~v.w;
            end
            if (fp_ack != 3'b000) begin
                got = 1;
                lat = n;
                ackv = fp_ack;
                fp_req[v.ch] = 1'b0;
            end
        end
        check("vec_ack_seen", 32'(got), 1);
        e = sb.pop_front();
        check("vec_ack_onehot", 32'(ackv), 32'(3'b001 << e.ch));
        check("vec_rdata", 32'(fp_rdata), 32'(e.rd));
        check("vec_latency", lat, FP_WAIT + 1);
        check("vec_sram_a", 32'(a0), 32'(v.a));
        if (v.w) check("vec_sram_dout", 32'(d0), 32'(v.d));
        check("vec_oe_cycles", oe_lo, v.w ? 0 : FP_WAIT + 1);
        check("vec_we_cycles", we_lo, v.w ? FP_WAIT : 0);
        check("vec_doe_cycles", doe_hi, v.w ? FP_WAIT + 2 : 0);
        @(negedge clk);
        check("idle_ack", 32'(fp_ack), 0);
        check("idle_strobes", {29'd0, fp_oe_n, fp_we_n, fp_doe}, 32'b110);
        check("idle_a_hold", 32'(fp_a), 32'(v.a));
        check("idle_rdata_hold", 32'(fp_rdata), 32'(e.rd));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nack, t0, tprev;
        int ord[$];
        int tim[$];

        vecs[0] = '{0, 1'b1, 14'h0010, 8'h11, 8'h00};
        vecs[1] = '{1, 1'b1, 14'h3FFF, 8'hEE, 8'h00};
        vecs[2] = '{2, 1'b0, 14'h0010, 8'h00, 8'h11};
        vecs[3] = '{0, 1'b0, 14'h3FFF, 8'h00, 8'hEE};
        vecs[4] = '{1, 1'b0, 14'h1234, 8'h00, 8'hA5};
        vecs[5] = '{2, 1'b1, 14'h0007, 8'h3C, 8'hA5};
        vecs[6] = '{0, 1'b0, 14'h0007, 8'h00, 8'h3C};

        rst = 1'b1;
        fp_req = '0; fp_wr = '0; fp_addr = '0; fp_wdata = '0;
        rr_req = '0; rr_wr = '0; rr_addr = '0; rr_wdata = '0;
        w3_req = '0; w3_wr = '0; w3_addr = '0; w3_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(fp_ack), 0);
        check("rst_strobes", {29'd0, fp_oe_n, fp_we_n, fp_doe}, 32'b110);
        check("rst_rdata", 32'(fp_rdata), 0);
        check("rst_sram_a", 32'(fp_a), 0);
        check("rst_sram_dout", 32'(fp_dout), 0);
        check("rst_w3_a", 32'(w3_a), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_fp(vecs[i]);

        // all three channels contending on the fixed-priority arbiter
        @(negedge clk);
        fp_wr = 3'b000;
        fp_addr = {14'h1234, 14'h3FFF, 14'h0010};
        fp_req = 3'b111;
        nack = 0;
        for (int c = 0; c < 40 && nack < 3; c++) begin
            @(negedge clk);
            if (fp_ack != 3'b000) begin
                check("fp_contend_onehot", $countones(fp_ack), 1);
                for (int i = 0; i < 3; i++) begin
                    if (fp_ack[i]) begin
                        ord.push_back(i);
                        tim.push_back(c);
                        fp_req[i] = 1'b0;
                    end
                end
                nack++;
            end
        end
        check("fp_contend_acks", nack, 3);
        for (int k = 0; k < ord.size(); k++) check("fp_order", ord[k], k);
        for (int k = 1; k < tim.size(); k++) check("fp_period", tim[k] - tim[k-1], FP_WAIT + 3);
        check("fp_contend_rdata", 32'(fp_rdata), 32'hA5);

        // asynchronous reset during the second ACCESS cycle of a read
        @(negedge clk);
        fp_req[1] = 1'b1; fp_wr[1] = 1'b0; fp_addr[14 +: 14] = 14'h1234;
        @(negedge clk);
        check("arst_read_started", 32'(fp_oe_n), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_strobes", {29'd0, fp_oe_n, fp_we_n, fp_doe}, 32'b110);
        check("arst_ack", 32'(fp_ack), 0);
        check("arst_rdata", 32'(fp_rdata), 0);
        check("arst_sram_a", 32'(fp_a), 0);
        fp_req = '0;
        repeat (2) begin
            @(negedge clk);
            check("arst_no_ack", 32'(fp_ack), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("arst_post_no_ack", 32'(fp_ack), 0);
        run_fp('{1, 1'b0, 14'h1234, 8'h00, 8'hA5});

        // round-robin with every channel held requesting
        ord.delete(); tim.delete();
        @(negedge clk);
        rr_req = 3'b111;
        nack = 0;
        for (int c = 0; c < 60 && nack < 6; c++) begin
            @(negedge clk);
            if (rr_ack != 3'b000) begin
                for (int i = 0; i < 3; i++) if (rr_ack[i]) ord.push_back(i);
                tim.push_back(c);
                nack++;
            end
        end
        rr_req = '0;
        check("rr_acks", nack, 6);
        for (int k = 0; k < ord.size(); k++) check("rr_order", ord[k], k % 3);
        for (int k = 1; k < tim.size(); k++) check("rr_period", tim[k] - tim[k-1], 4);

        // slow SRAM, top of a 128 KB space, two back-to-back reads
        @(negedge clk);
        w3_req = 1'b1; w3_wr = 1'b0; w3_addr = 17'h1FFFF;
        nack = 0; t0 = -1; tprev = -1;
        begin
            int oe_lo;
            oe_lo = 0;
            for (int c = 0; c < 40 && nack < 2; c++) begin
                @(negedge clk);
                if (c == 0) check("w3_sram_a", 32'(w3_a), 32'h1FFFF);
                if (nack == 0 && !w3_oe_n) oe_lo++;
                if (w3_ack != 1'b0) begin
                    if (nack == 0) t0 = c;
                    else tprev = c;
                    check("w3_rdata", 32'(w3_rdata), 32'hC3);
                    nack++;
                end
            end
            w3_req = 1'b0;
            check("w3_acks", nack, 2);
            check("w3_oe_cycles", oe_lo, 4);
            check("w3_latency", t0, 4);
            check("w3_period", tprev - t0, 6);
        end
        @(negedge clk);
        check("w3_idle_strobes", {29'd0, w3_oe_n, w3_we_n, w3_doe}, 32'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vdp_vram_arb.md
VDP_VRAM_ARB -- requirements
Module: vdp_vram_arb

Interface
REQ-001 SHALL have parameter NCH, default 3: number of requester channels; legal range 1..8.
REQ-002 SHALL have parameter AW, default 14: VRAM address width; 14 gives 16 KB and 17 gives 128 KB.
REQ-003 SHALL have parameter WAIT, default 1: SRAM strobe cycles per access; WAIT >= 1.
REQ-004 SHALL have parameter RR, default 0: 0 selects fixed priority (channel 0 highest); 1 selects round-robin.
REQ-005 SHALL have these ports, each given as name, direction, width, meaning:
- clk40m, in, 1: the only clock; all state changes on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req, in, NCH: per-channel access request, held high until the matching ack.
- wr, in, NCH: per-channel write flag (1 write, 0 read).
- addr, in, NCH*AW: packed per-channel address; channel i occupies bits [i*AW +: AW].
- wdata, in, NCH*8: packed per-channel write data.
- ack, out, NCH: one-cycle completion pulse per channel.
- rdata, out, 8: last read data.
- sram_a, out, AW: SRAM address.
- sram_din, in, 8: SRAM read data.
- sram_dout, out, 8: SRAM write data.
- sram_doe, out, 1: SRAM data output enable.
- sram_oe_n, out, 1: SRAM output enable, active low.
- sram_we_n, out, 1: SRAM write enable, active low.

Function
REQ-006 SHALL implement three states, IDLE, ACCESS and DONE, and SHALL enter IDLE on reset.
REQ-007 IDLE with any req bit high SHALL do the following on that edge:
- select a winner;
- latch the winner index, wr, addr and wdata;
- load sram_a and sram_dout;
- go to ACCESS with cycle counter = WAIT.
REQ-008 IDLE with no req bit high SHALL remain in IDLE with all strobes inactive.
REQ-009 RR=0 SHALL grant the lowest-numbered requesting channel.
REQ-010 RR=1 SHALL grant the first requesting channel found by searching upward from (last_grant+1) mod NCH. last_grant SHALL update only on a grant and SHALL have width max(1, clog2(NCH)).
REQ-011 ACCESS SHALL last exactly WAIT+1 cycles. The counter SHALL decrement each cycle, and the state SHALL exit to DONE on the edge where the counter equals 0.
REQ-012 A read in ACCESS SHALL drive sram_oe_n=0 for all WAIT+1 cycles, and rdata SHALL capture sram_din on the ACCESS exit edge.
REQ-013 A write SHALL drive:
- sram_doe=1 throughout ACCESS and DONE (data hold);
- sram_we_n=0 in every ACCESS cycle except the first (address setup).
REQ-014 DONE SHALL last one cycle, SHALL drive ack[winner]=1 with all other ack bits 0, SHALL drive sram_oe_n=1 and sram_we_n=1, and SHALL then return to IDLE.
REQ-015 A grant at edge k SHALL produce ack high during cycle k+WAIT+2; back-to-back grants SHALL have a period of WAIT+3 cycles.
REQ-016 A requester SHALL drop req on the edge that samples its ack. The arbiter SHALL NOT be required to tolerate req still high in the IDLE cycle after DONE; if req is still high, the arbiter SHALL issue a new grant.
REQ-017 A req that falls during ACCESS SHALL NOT abort the access; the access SHALL complete and the ack SHALL still pulse.
REQ-018 Changes to addr, wr or wdata after the grant SHALL be ignored until the next IDLE grant.
REQ-019 rdata SHALL hold its value across writes and idle periods and SHALL change only on read completion.
REQ-020 sram_a and sram_dout SHALL hold their value after DONE until the next grant.
REQ-021 With NCH=1, the arbiter SHALL behave identically with no arbitration logic; the RR setting SHALL be irrelevant.

Reset
REQ-022 rst=1 SHALL immediately, regardless of clock, force the following, and SHALL abandon any in-flight access with no ack:
- state=IDLE;
- ack=0;
- rdata=0;
- sram_a=0 and sram_dout=0;
- sram_doe=0;
- sram_oe_n=1 and sram_we_n=1;
- counter=0;
- last_grant=NCH-1.
REQ-023 The first grant after reset SHALL go to channel 0 under both RR settings when channel 0 requests.

Verification
REQ-024 Use NCH=3, AW=14, WAIT=1. Read on ch1 of addr 0x1234 with the SRAM model returning 0xA5: grant at edge k; sram_a=0x1234; oe_n low for 2 cycles; ack[1] high in cycle k+3; rdata=0xA5.
REQ-025 Write on ch2 of 0x3C to addr 0x0007: doe=1 for 3 cycles; we_n low for exactly 1 cycle (the second ACCESS cycle); the model holds 0x3C at 0x0007; ack[2] pulses once.
REQ-026 RR=0, all three channels requesting continuously with each dropping req on its ack: grant order 0,1,2 with a period of 4 cycles.
REQ-027 RR=1, channel 0 re-raising req immediately and channels 1 and 2 held high: grant order 0,1,2,0,1,2 with no channel starved.
REQ-028 Async rst asserted mid-read on the second ACCESS cycle: strobes inactive before the next edge, no ack, rdata=0; the next read after reset completes normally.
REQ-029 AW=17, WAIT=3, read of addr 0x1FFFF: sram_a=0x1FFFF; oe_n low for 4 cycles; ack 5 cycles after grant.
